// File: rtl/walk_service_fsm.sv
// ---------------------------------------------------------------------------
// walk_service_fsm
//
// Main/side intersection light sequencer with pedestrian walk service.
// The cycle is MG1 -> MG2 -> MY -> (WALK) -> SG -> SY -> MG1. Dwell times
// are counted in ticks from an internal prescaler. A pending walk request
// is served between MY and SG, and the walk register is cleared by a
// one-cycle pulse on entry to WALK.
//
// Ports:
//   clk          in   1  rising-edge clock
//   Reset        in   1  asynchronous active-high reset
//   Sensor_Sync  in   1  side-street car present (already synchronised)
//   WR           in   1  latched walk request
//   Main_Light   out  3  main street {R,Y,G}, one-hot
//   Side_Light   out  3  side street {R,Y,G}, one-hot
//   Walk_Lamp    out  1  pedestrian walk indication (WALK only)
//   WR_Reset     out  1  one-cycle clear pulse to the walk register
// ---------------------------------------------------------------------------
module walk_service_fsm #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_SHORT  = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_WALK   = 3
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sensor_Sync,
  input  logic       WR,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Lamp,
  output logic       WR_Reset
);

  // Dwell values are held in an 8-bit counter; 0 is promoted to 1 and
  // anything above 255 is held at 255 so the compare always terminates.
  function automatic logic [7:0] clamp_dwell(input int unsigned t);
    logic [7:0] r;
    if (t == 32'd0) begin
      r = 8'd1;
    end else if (t > 32'd255) begin
      r = 8'd255;
    end else begin
      r = t[7:0];
    end
    return r;
  endfunction

  localparam int unsigned DIV_C = (TICK_DIV < 32'd1) ? 32'd1 : TICK_DIV;
  localparam int unsigned PW    = (DIV_C > 32'd1) ? $clog2(DIV_C) : 32'd1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV_C - 32'd1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  // Stored as dwell-1 so the transition compare uses elapsed directly.
  localparam logic [7:0] D_BASE_M1  = clamp_dwell(T_BASE)  - 8'd1;
  localparam logic [7:0] D_SHORT_M1 = clamp_dwell(T_SHORT) - 8'd1;
  localparam logic [7:0] D_YEL_M1   = clamp_dwell(T_YEL)   - 8'd1;
  localparam logic [7:0] D_WALK_M1  = clamp_dwell(T_WALK)  - 8'd1;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  state_e        next_state_s;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic [7:0]    dwell_m1_s;
  logic          short_q, short_d;
  logic          tick_s;

  logic [2:0]    main_light_q, main_light_d;
  logic [2:0]    side_light_q, side_light_d;
  logic          walk_lamp_q, walk_lamp_d;
  logic          wr_reset_q, wr_reset_d;

  assign tick_s = (presc_q == PRESC_MAX);

  // Per-state dwell and successor; WR is only looked at while in MY.
  always_comb begin
    dwell_m1_s   = D_BASE_M1;
    next_state_s = MG1;
    case (state_q)
      MG1: begin
        dwell_m1_s   = D_BASE_M1;
        next_state_s = MG2;
      end
      MG2: begin
        // short_q holds the sensor sampled on the MG1 exit cycle.
        if (short_q) begin
          dwell_m1_s = D_SHORT_M1;
        end else begin
          dwell_m1_s = D_BASE_M1;
        end
        next_state_s = MY;
      end
      MY: begin
        dwell_m1_s = D_YEL_M1;
        if (WR) begin
          next_state_s = WALK;
        end else begin
          next_state_s = SG;
        end
      end
      WALK: begin
        dwell_m1_s   = D_WALK_M1;
        next_state_s = SG;
      end
      SG: begin
        dwell_m1_s   = D_BASE_M1;
        next_state_s = SY;
      end
      SY: begin
        dwell_m1_s   = D_YEL_M1;
        next_state_s = MG1;
      end
      default: begin
        dwell_m1_s   = D_BASE_M1;
        next_state_s = MG1;
      end
    endcase
  end

  // Prescaler, elapsed-tick counter and state advance.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    short_d   = short_q;
    if (tick_s) begin
      // The prescaler wraps on every tick, which also covers the clear
      // required on a state transition.
      presc_d = PRESC_ZERO;
      if (elapsed_q == dwell_m1_s) begin
        state_d   = next_state_s;
        elapsed_d = 8'd0;
        if (state_q == MG1) begin
          short_d = Sensor_Sync;
        end else begin
          short_d = short_q;
        end
      end else if (elapsed_q != 8'hFF) begin
        elapsed_d = elapsed_q + 8'd1;
      end else begin
        elapsed_d = elapsed_q;
      end
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Output decode from the next state so the registered outputs change
  // in the same cycle as the state register.
  always_comb begin
    main_light_d = LIGHT_G;
    side_light_d = LIGHT_R;
    walk_lamp_d  = 1'b0;
    wr_reset_d   = 1'b0;
    case (state_d)
      MG1, MG2: begin
        main_light_d = LIGHT_G;
        side_light_d = LIGHT_R;
      end
      MY: begin
        main_light_d = LIGHT_Y;
        side_light_d = LIGHT_R;
      end
      WALK: begin
        main_light_d = LIGHT_R;
        side_light_d = LIGHT_R;
        walk_lamp_d  = 1'b1;
        // Clear pulse only on the entry cycle, so a request raised later
        // in the same WALK survives until the next MY exit.
        if (state_q != WALK) begin
          wr_reset_d = 1'b1;
        end else begin
          wr_reset_d = 1'b0;
        end
      end
      SG: begin
        main_light_d = LIGHT_R;
        side_light_d = LIGHT_G;
      end
      SY: begin
        main_light_d = LIGHT_R;
        side_light_d = LIGHT_Y;
      end
      default: begin
        main_light_d = LIGHT_G;
        side_light_d = LIGHT_R;
      end
    endcase
  end

  // State, timing and output registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= MG1;
      presc_q      <= PRESC_ZERO;
      elapsed_q    <= 8'd0;
      short_q      <= 1'b0;
      main_light_q <= LIGHT_G;
      side_light_q <= LIGHT_R;
      walk_lamp_q  <= 1'b0;
      wr_reset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      elapsed_q    <= elapsed_d;
      short_q      <= short_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_lamp_q  <= walk_lamp_d;
      wr_reset_q   <= wr_reset_d;
    end
  end

  assign Main_Light = main_light_q;
  assign Side_Light = side_light_q;
  assign Walk_Lamp  = walk_lamp_q;
  assign WR_Reset   = wr_reset_q;

endmodule

// File: tb/tb_walk_service_fsm.sv
// ---------------------------------------------------------------------------
// tb_walk_service_fsm
//
// Scoreboard bench. The stimulus process pushes the expected sequence of
// output segments (lights, walk lamp, length in cycles, clear pulse on the
// first cycle) and reset snapshots. The monitor samples on falling edges,
// groups identical output values into segments and compares each finished
// segment against the queue. MG1 and MG2 show the same lights, so they
// appear as one green segment of (T_BASE + D2) * TICK_DIV cycles.
// ---------------------------------------------------------------------------
module tb_walk_service_fsm;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Sensor_Sync = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_reg = 1'b0;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk_Lamp;
  logic       WR_Reset;

  walk_service_fsm #(
    .TICK_DIV(4),
    .T_BASE  (6),
    .T_SHORT (3),
    .T_YEL   (2),
    .T_WALK  (3)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Sensor_Sync(Sensor_Sync),
    .WR         (wr_reg),
    .Main_Light (Main_Light),
    .Side_Light (Side_Light),
    .Walk_Lamp  (Walk_Lamp),
    .WR_Reset   (WR_Reset)
  );

  always #5 clk = ~clk;

  // Walk request register model: set by the bench, cleared by WR_Reset.
  always @(posedge clk) begin
    if (WR_Reset) wr_reg <= 1'b0;
    else if (wr_req) wr_reg <= 1'b1;
  end

  typedef struct {
    logic       is_rst;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    int         len;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seg(input logic [2:0] m, input logic [2:0] s, input logic w,
                          input int len, input logic p);
    exp_t e;
    e.is_rst = 1'b0;
    e.main   = m;
    e.side   = s;
    e.walk   = w;
    e.len    = len;
    e.pulse  = p;
    exp_q.push_back(e);
  endtask

  task automatic push_rst();
    exp_t e;
    e.is_rst = 1'b1;
    e.main   = 3'b001;
    e.side   = 3'b100;
    e.walk   = 1'b0;
    e.len    = 0;
    e.pulse  = 1'b0;
    exp_q.push_back(e);
  endtask

  // One lap: main green (MG1+MG2), MY 8, optional WALK 12, SG 24, SY 8.
  task automatic push_lap(input int green, input logic walk);
    push_seg(3'b001, 3'b100, 1'b0, green, 1'b0);
    push_seg(3'b010, 3'b100, 1'b0, 8, 1'b0);
    if (walk) push_seg(3'b100, 3'b100, 1'b1, 12, 1'b1);
    push_seg(3'b100, 3'b001, 1'b0, 24, 1'b0);
    push_seg(3'b100, 3'b010, 1'b0, 8, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic [6:0] seg_val = 7'd0;
  logic [6:0] cur = 7'd0;
  int         seg_len = 0;
  logic       seg_first_pulse = 1'b0;
  int         seg_extra = 0;
  bit         in_rst = 1'b0;

  task automatic close_seg();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL seg_unexpected: got seg %0h len %0d, nothing expected", seg_val, seg_len);
    end else begin
      e = exp_q.pop_front();
      chk("seg_kind", 32'd0, {31'd0, e.is_rst});
      chk("seg_main", {29'd0, seg_val[6:4]}, {29'd0, e.main});
      chk("seg_side", {29'd0, seg_val[3:1]}, {29'd0, e.side});
      chk("seg_walk", {31'd0, seg_val[0]}, {31'd0, e.walk});
      chk("seg_len", seg_len, e.len);
      chk("seg_first_pulse", {31'd0, seg_first_pulse}, {31'd0, e.pulse});
      chk("seg_extra_pulses", seg_extra, 32'd0);
    end
    seg_len = 0;
  endtask

  task automatic check_rst();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rst_unexpected: got reset, nothing expected");
    end else begin
      e = exp_q.pop_front();
      chk("rst_kind", 32'd1, {31'd0, e.is_rst});
      chk("rst_main", {29'd0, Main_Light}, {29'd0, e.main});
      chk("rst_side", {29'd0, Side_Light}, {29'd0, e.side});
      chk("rst_walk", {31'd0, Walk_Lamp}, {31'd0, e.walk});
      chk("rst_wr_reset", {31'd0, WR_Reset}, 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge Reset);
      if (Reset) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          if (seg_len != 0) close_seg();
          #1;
          check_rst();
        end
      end else begin
        in_rst = 1'b0;
        cur = {Main_Light, Side_Light, Walk_Lamp};
        if (seg_len != 0 && cur == seg_val) begin
          seg_len++;
          if (WR_Reset) seg_extra++;
        end else begin
          if (seg_len != 0) close_seg();
          seg_val         = cur;
          seg_len         = 1;
          seg_first_pulse = WR_Reset;
          seg_extra       = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int now = 0;

  // Advance to just after rising edge 'target' counted from the last release.
  task automatic goto(input int target);
    while (now < target) begin
      @(posedge clk);
      now++;
    end
    #1;
  endtask

  initial begin
    // Power-on reset, then a lap cut short by reset 10 cycles into SG.
    push_rst();
    push_lap(48, 1'b0);
    void'(exp_q.pop_back());  // SY not reached
    void'(exp_q.pop_back());  // full SG replaced by truncated one
    push_seg(3'b100, 3'b001, 1'b0, 10, 1'b0);
    push_rst();
    #2 Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    now = 0;
    goto(66);
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    now = 0;

    // Lap 1: idle, period 88.
    push_lap(48, 1'b0);
    goto(88);
    // Lap 2: sensor high only on the MG1 exit cycle -> MG2 12, period 76.
    push_lap(36, 1'b0);
    goto(111);
    Sensor_Sync = 1'b1;
    goto(112);
    Sensor_Sync = 1'b0;
    goto(164);
    // Lap 3: request raised during MG2 is served.
    push_lap(48, 1'b1);
    goto(200);
    wr_req = 1'b1;
    goto(201);
    wr_req = 1'b0;
    goto(264);
    // Lap 4: request appears in the first SG cycle -> no walk this lap.
    push_lap(48, 1'b0);
    goto(319);
    wr_req = 1'b1;
    goto(320);
    wr_req = 1'b0;
    goto(352);
    // Lap 5: late request served; re-raised inside WALK after the clear.
    push_lap(48, 1'b1);
    goto(412);
    wr_req = 1'b1;
    goto(413);
    wr_req = 1'b0;
    goto(452);
    // Lap 6: re-raised request served with its own single pulse.
    push_lap(48, 1'b1);
    goto(552);
    // Lap 7: reset lands while the WALK clear pulse is still up.
    push_seg(3'b001, 3'b100, 1'b0, 48, 1'b0);
    push_seg(3'b010, 3'b100, 1'b0, 8, 1'b0);
    push_seg(3'b100, 3'b100, 1'b1, 1, 1'b1);
    push_rst();
    goto(560);
    wr_req = 1'b1;
    goto(561);
    wr_req = 1'b0;
    goto(608);
    #6 Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    now = 0;
    // The surviving request is served at the first MY exit after reset.
    push_lap(48, 1'b1);
    goto(110);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("wr_cleared", {31'd0, wr_reg}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
